// File: rtl/alu_serial_rx.sv
// Serial command receiver: frames 11-bit packets from sin, collects up to eight
// data bytes plus a control packet, checks count/CRC/opcode, and buffers one command.
module alu_serial_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sin,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_a,
   output logic [31:0] cmd_b,
   output logic [2:0]  cmd_op,
   output logic [2:0]  cmd_err,
   output logic        overrun
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  pkt_q, pkt_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic [63:0] sr_q, sr_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [31:0] cmd_a_q, cmd_a_d;
   logic [31:0] cmd_b_q, cmd_b_d;
   logic [2:0]  cmd_op_q, cmd_op_d;
   logic [2:0]  cmd_err_q, cmd_err_d;
   logic        overrun_q, overrun_d;

   logic        new_cmd;
   logic [63:0] new_ab;
   logic [2:0]  new_op;
   logic [2:0]  new_err;
   logic [6:0]  pad_bits;
   logic [63:0] aligned;
   logic [2:0]  ctl_op;
   logic [3:0]  ctl_crc;
   logic [3:0]  calc_crc;
   logic        op_ok;

   // MSB-first serial CRC-4, polynomial x^4+x+1, init 0, no final XOR.
   function automatic logic [3:0] crc4(input logic [67:0] v);
      logic [3:0] c;
      logic       fb;
      c = 4'b0000;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ v[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   // Received bytes sit at the LSB end; left-align so byte 1 lands in B[31:24]
   // and missing trailing bytes read as zero.
   always_comb begin
      pad_bits = 7'd64 - {byte_cnt_q, 3'b000};
      aligned  = sr_q << pad_bits;
      ctl_op   = pkt_q[7:5];
      ctl_crc  = pkt_q[4:1];
      calc_crc = crc4({aligned, 1'b1, ctl_op});
      op_ok    = (ctl_op == 3'b000) || (ctl_op == 3'b001) ||
                 (ctl_op == 3'b100) || (ctl_op == 3'b101);
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      pkt_d      = pkt_q;
      byte_cnt_d = byte_cnt_q;
      sr_d       = sr_q;
      new_cmd    = 1'b0;
      new_ab     = aligned;
      new_op     = 3'b000;
      new_err    = 3'b000;
      case (state_q)
         S_IDLE: begin
            if (!sin) begin
               state_d   = S_SHIFT;
               bit_cnt_d = 4'd10;
            end
         end
         S_SHIFT: begin
            pkt_d     = {pkt_q[8:0], sin};
            bit_cnt_d = bit_cnt_q - 4'd1;
            if (bit_cnt_q == 4'd1) state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_IDLE;
            if (!pkt_q[0]) begin
               new_cmd    = 1'b1;
               new_err    = 3'b100;
               byte_cnt_d = 4'd0;
               sr_d       = 64'd0;
            end else if (!pkt_q[9]) begin
               if (byte_cnt_q == 4'd8) begin
                  new_cmd    = 1'b1;
                  new_err    = 3'b100;
                  new_ab     = 64'd0;
                  byte_cnt_d = 4'd0;
                  sr_d       = 64'd0;
               end else begin
                  sr_d       = {sr_q[55:0], pkt_q[8:1]};
                  byte_cnt_d = byte_cnt_q + 4'd1;
               end
            end else begin
               new_cmd    = 1'b1;
               new_op     = ctl_op;
               byte_cnt_d = 4'd0;
               sr_d       = 64'd0;
               if (byte_cnt_q != 4'd8)    new_err = 3'b100;
               else if (calc_crc != ctl_crc) new_err = 3'b010;
               else if (!op_ok)           new_err = 3'b001;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake: cmd_valid holds with stable outputs until a posedge sees
   // cmd_valid && cmd_ready; a command completing on that same edge replaces it.
   always_comb begin
      cmd_valid_d = cmd_valid_q && !cmd_ready;
      cmd_a_d     = cmd_a_q;
      cmd_b_d     = cmd_b_q;
      cmd_op_d    = cmd_op_q;
      cmd_err_d   = cmd_err_q;
      overrun_d   = overrun_q;
      if (new_cmd) begin
         if (!cmd_valid_q || cmd_ready) begin
            cmd_valid_d = 1'b1;
            cmd_b_d     = new_ab[63:32];
            cmd_a_d     = new_ab[31:0];
            cmd_op_d    = new_op;
            cmd_err_d   = new_err;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 4'd0;
         pkt_q       <= 10'd0;
         byte_cnt_q  <= 4'd0;
         sr_q        <= 64'd0;
         cmd_valid_q <= 1'b0;
         cmd_a_q     <= 32'd0;
         cmd_b_q     <= 32'd0;
         cmd_op_q    <= 3'b000;
         cmd_err_q   <= 3'b000;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         pkt_q       <= pkt_d;
         byte_cnt_q  <= byte_cnt_d;
         sr_q        <= sr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_a_q     <= cmd_a_d;
         cmd_b_q     <= cmd_b_d;
         cmd_op_q    <= cmd_op_d;
         cmd_err_q   <= cmd_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_a     = cmd_a_q;
   assign cmd_b     = cmd_b_q;
   assign cmd_op    = cmd_op_q;
   assign cmd_err   = cmd_err_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/alu_serial_rx.md
# alu_serial_rx

Serial command receiver for the serial ALU. It samples the single-wire `sin` stream, frames it into 11-bit packets, and collects up to eight data bytes followed by one control packet. It checks packet count, CRC-4 and opcode, then presents one parallel command (A, B, op, error class) to the ALU core over a valid/ready handshake.

## Interface
- No parameters; all widths fixed by the serial protocol.
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- sin  in  1  serial input; idle high; changes on negedge, sampled on posedge.
- cmd_valid  out  1  command available; held until accepted.
- cmd_ready  in  1  core accepts when cmd_valid && cmd_ready at posedge.
- cmd_a  out  32  operand A (bytes 5..8 received).
- cmd_b  out  32  operand B (bytes 1..4 received, first byte = B[31:24]).
- cmd_op  out  3  opcode from control packet.
- cmd_err  out  3  one-hot {err_data, err_crc, err_op}; 000 = good command.
- overrun  out  1  sticky; command completed while previous still pending; cleared only by reset.

## Operation
- Packet format, MSB first: bit10 start (0), bit9 type (0 data, 1 control), bits8:1 payload, bit0 stop (1).
- Data payload is one byte.
- Control payload is {1'b0, op[2:0], crc[3:0]}.
- Bit FSM:
  - IDLE: leave on a sampled `sin`=0 (start bit); bit counter = 10.
  - SHIFT: shift one bit per cycle until the stop bit is sampled, then DECODE for one cycle, then IDLE.
- Framing error (stop bit 0): discard the packet, abort the current command, report err_data. No second start is accepted in the DECODE cycle.
- Command collector: byte count 0..8, 64-bit shift register {B,A}; each data byte is shifted in at the LSB end.
  - 9th data packet: emit a command with err_data; A/B/op = 0; count resets.
  - Control packet: emit a command, then count resets to 0.
- Checks on a control packet, in priority order (exactly one cmd_err bit set):
  - count != 8 -> err_data.
  - CRC mismatch -> err_crc.
  - op not in {000 and, 001 or, 100 add, 101 sub} -> err_op.
- CRC: CRC-4, polynomial x^4+x+1, init 0000, no final XOR. Computed over the 68-bit vector {B, A, 1'b1, op}, MSB (B[31]) first. Computed combinationally in DECODE.
- On any error, cmd_a/cmd_b/cmd_op carry the received values (zero-filled for missing bytes) so the core can build its error packet.
- Output buffer is one entry.
  - If a new command completes while cmd_valid=1 and cmd_ready=0, the new command is dropped, overrun is set, and the pending outputs stay unchanged.
  - If accepted in the same cycle a new command completes, the new command is loaded.

## Timing
- Reset values: cmd_valid=0, cmd_a=0, cmd_b=0, cmd_op=0, cmd_err=000, overrun=0; FSM IDLE, count 0.
- Reset mid-packet or mid-command discards all partial state immediately (asynchronous).
- Stop bit sampled at edge N -> cmd_valid high after edge N+1 (one-cycle latency).
- The next start bit can be sampled at edge N+2.
- cmd_valid drops the cycle after the acceptance edge unless a new command loads on that edge.
- cmd_ready is ignored while cmd_valid=0.
- Back-to-back packets with no idle bit between the stop bit and the next start bit must not be supported. The protocol guarantees at least one idle cycle, and the receiver simply re-enters IDLE.
- `sin` held low continuously after reset: frames a packet whose stop bit = 0 -> framing error. Then it re-frames from the next 0.

## Test plan
- Good command: B=32'h0000_0003, A=32'h0000_0005, op=100, correct CRC, 8 data packets + ctl -> after stop+1 edge: cmd_valid=1, cmd_b=3, cmd_a=5, cmd_op=100, cmd_err=000.
- Short command: 5 data packets + ctl with valid CRC for the padded vector -> cmd_err=100, cmd_b holds the first 4 bytes, cmd_a[31:24] = 5th byte, rest 0.
- Long command: 9 data packets of 8'hFF, no ctl -> command on the 9th packet with cmd_err=100 and A=B=0. A following good command decodes cleanly.
- CRC: good A/B, op=001 with CRC XOR 4'hF -> cmd_err=010; op=011 with correct CRC -> cmd_err=001.
- Backpressure: cmd_ready=0, two good commands -> first held stable, second dropped, overrun=1. Raise cmd_ready -> first accepted, cmd_valid=0 next cycle.
- Reset: assert rst_n=0 during the 6th data packet, release, send a good command -> all outputs 0 during reset, then one correct command with cmd_err=000.
